// File: rtl/sobel_pkg.sv
// Shared widths, kernel weights and helpers for the streaming Sobel edge-magnitude core.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int GRAD_W  = 11;
  localparam int MAG_W   = 12;
  localparam int SAT_MAX = 255;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [MAG_W-1:0]         mag_t;

  localparam grad_t K_EDGE = 11'sd1;
  localparam grad_t K_MID  = 11'sd2;

  typedef struct packed {
    logic  valid;
    logic  last;
    grad_t gx;
    grad_t gy;
  } grad_stage_t;

  function automatic grad_t to_grad(input pix_t p);
    to_grad = $signed({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  // |g| never exceeds 1020, so the 11-bit negation cannot overflow.
  function automatic mag_t abs_mag(input grad_t g);
    logic [GRAD_W-1:0] a;
    a = g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
    abs_mag = {1'b0, a};
  endfunction

  function automatic pix_t sat8(input mag_t mag, input logic [1:0] shift);
    mag_t m;
    m = mag >> shift;
    if (m > MAG_W'(SAT_MAX)) begin
      sat8 = PIX_W'(SAT_MAX);
    end else begin
      sat8 = m[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-clock shift RAM: dout is the sample written DEPTH enabled cycles ago (read-before-write).
module sobel_line_buffer #(
  parameter int DEPTH = 320,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  assign dout = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH-1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel edge magnitude: line buffers + window, two-stage gradient/magnitude pipeline,
// sticky last-result byte for PIO readback.
module sobel_stream_core
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int MAG_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  input  logic       sof,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic [7:0] res_hold,
  output logic       frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic             frame_start;

  pix_t             lb0_out, lb1_out;
  pix_t [2:0][2:0]  win_q, win_d;

  logic             v0_q, v0_d;
  logic             last0_q, last0_d;
  grad_stage_t      s1_q, s1_d;
  mag_t             mag;

  logic             res_valid_q, res_valid_d;
  pix_t             res_data_q, res_data_d;
  pix_t             res_hold_q, res_hold_d;
  logic             frame_done_q, frame_done_d;

  assign frame_start = pix_valid & sof;

  // Row-1 and row-2 taps for the incoming column.
  sobel_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .W     (PIX_W)
  ) u_lb0 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pix_valid),
    .din     (pix_data),
    .dout    (lb0_out)
  );

  sobel_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .W     (PIX_W)
  ) u_lb1 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pix_valid),
    .din     (lb0_out),
    .dout    (lb1_out)
  );

  always_comb begin
    cur_col = frame_start ? '0 : col_q;
    cur_row = frame_start ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    if (pix_valid) begin
      if (cur_col == COL_W'(IMG_WIDTH-1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(IMG_HEIGHT-1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_out;
      win_d[1][2] = lb0_out;
      win_d[2][2] = pix_data;
    end
    v0_d    = pix_valid && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    last0_d = v0_d && (cur_row == ROW_W'(IMG_HEIGHT-1)) && (cur_col == COL_W'(IMG_WIDTH-1));
  end

  // A qualified sof kills whatever is still in the two pipeline stages.
  always_comb begin
    s1_d.valid = v0_q & ~frame_start;
    s1_d.last  = last0_q;
    s1_d.gx    = (K_EDGE * to_grad(win_q[0][2]) + K_MID * to_grad(win_q[1][2]) + K_EDGE * to_grad(win_q[2][2]))
               - (K_EDGE * to_grad(win_q[0][0]) + K_MID * to_grad(win_q[1][0]) + K_EDGE * to_grad(win_q[2][0]));
    s1_d.gy    = (K_EDGE * to_grad(win_q[2][0]) + K_MID * to_grad(win_q[2][1]) + K_EDGE * to_grad(win_q[2][2]))
               - (K_EDGE * to_grad(win_q[0][0]) + K_MID * to_grad(win_q[0][1]) + K_EDGE * to_grad(win_q[0][2]));
  end

  always_comb begin
    mag          = abs_mag(s1_q.gx) + abs_mag(s1_q.gy);
    res_valid_d  = s1_q.valid & ~frame_start;
    res_data_d   = res_data_q;
    res_hold_d   = res_hold_q;
    if (res_valid_d) begin
      res_data_d = sat8(mag, 2'(MAG_SHIFT));
      res_hold_d = sat8(mag, 2'(MAG_SHIFT));
    end
    frame_done_d = res_valid_d & s1_q.last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      v0_q         <= 1'b0;
      last0_q      <= 1'b0;
      s1_q         <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_hold_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      v0_q         <= v0_d;
      last0_q      <= last0_d;
      s1_q         <= s1_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_hold_q   <= res_hold_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_hold   = res_hold_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed bench for sobel_stream_core on an 8x6 frame; two instances (MAG_SHIFT 0 and 2) see identical stimulus.
module tb_sobel_stream_core;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] pix_data = '0;

  logic       rv0, fd0, rv2, fd2;
  logic [7:0] rd0, rh0, rd2, rh2;

  always #5 clk = ~clk;

  sobel_stream_core #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data), .sof(sof),
    .res_valid(rv0), .res_data(rd0), .res_hold(rh0), .frame_done(fd0));

  sobel_stream_core #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_SHIFT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data), .sof(sof),
    .res_valid(rv2), .res_data(rd2), .res_hold(rh2), .frame_done(fd2));

  typedef struct {
    int         acc;
    logic [7:0] e0;
    logic [7:0] e2;
    logic       last;
  } exp_t;

  typedef struct {
    string      name;
    int         pat;
    int         max_gap;
    bit         sof_abort;
    int         exp_res;
    int         exp_fd;
    logic [7:0] hold0;
    logic [7:0] hold2;
    logic [7:0] col0 [8];
    logic [7:0] col2 [8];
  } vec_t;

  vec_t vecs [5];
  exp_t q [$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int sof_acc = -100;
  int res_cnt0 = 0, res_cnt2 = 0, fd_cnt0 = 0, fd_cnt2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input int pat, input int c);
    logic [7:0] v;
    case (pat)
      0:       v = 8'd50;
      1:       v = 8'(10 * c);
      2:       v = (c >= 4) ? 8'd255 : 8'd0;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // Results appear exactly two edges after the enabling pixel; a qualified sof drops the two in flight.
  always @(negedge clk) begin
    if (rv0) res_cnt0++;
    if (rv2) res_cnt2++;
    if (fd0) fd_cnt0++;
    if (fd2) fd_cnt2++;
    while (q.size() > 0 && q[0].acc >= sof_acc - 2 && q[0].acc < sof_acc) void'(q.pop_front());
    if (q.size() > 0 && q[0].acc + 2 <= cyc) begin
      mon_e = q.pop_front();
      check("res_valid0", rv0, 1);
      check("res_data0", rd0, mon_e.e0);
      check("frame_done0", fd0, mon_e.last);
      check("res_valid2", rv2, 1);
      check("res_data2", rd2, mon_e.e2);
      check("frame_done2", fd2, mon_e.last);
    end else if (rv0 | rv2 | fd0 | fd2) begin
      check("unexpected_strobe", {rv0, rv2, fd0, fd2}, 0);
    end
  end

  task automatic drive(input logic [7:0] d, input logic s, input int r, input int c, input int vi);
    exp_t e;
    pix_valid = 1'b1;
    pix_data  = d;
    sof       = s;
    if (s) sof_acc = cyc + 1;
    if (r >= 2 && c >= 2) begin
      e.acc  = cyc + 1;
      e.e0   = vecs[vi].col0[c-1];
      e.e2   = vecs[vi].col2[c-1];
      e.last = (r == H-1) && (c == W-1);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic run_frame(input int vi, input int stop_r, input int stop_c, input bit use_sof);
    int gap;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        gap = (vecs[vi].max_gap > 0) ? int'($urandom_range(0, vecs[vi].max_gap)) : 0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        drive(pix(vecs[vi].pat, c), use_sof && r == 0 && c == 0, r, c, vi);
      end
    end
  endtask

  task automatic end_checks(input string name, input int exp_res, input int exp_fd,
                            input logic [7:0] h0, input logic [7:0] h2);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check({name, " res_count0"}, res_cnt0, exp_res);
    check({name, " res_count2"}, res_cnt2, exp_res);
    check({name, " frame_done_count0"}, fd_cnt0, exp_fd);
    check({name, " frame_done_count2"}, fd_cnt2, exp_fd);
    check({name, " res_hold0"}, rh0, h0);
    check({name, " res_hold2"}, rh2, h2);
    check({name, " pending_results"}, q.size(), 0);
  endtask

  initial begin
    vecs[0].name = "flat50";   vecs[0].pat = 0; vecs[0].max_gap = 0; vecs[0].sof_abort = 0;
    vecs[0].exp_res = 24; vecs[0].exp_fd = 1; vecs[0].hold0 = 8'd0;  vecs[0].hold2 = 8'd0;
    vecs[0].col0 = '{default: 8'd0};  vecs[0].col2 = '{default: 8'd0};

    vecs[1].name = "hramp";    vecs[1].pat = 1; vecs[1].max_gap = 0; vecs[1].sof_abort = 0;
    vecs[1].exp_res = 24; vecs[1].exp_fd = 1; vecs[1].hold0 = 8'd80; vecs[1].hold2 = 8'd20;
    vecs[1].col0 = '{default: 8'd80}; vecs[1].col2 = '{default: 8'd20};

    vecs[2].name = "vstep";    vecs[2].pat = 2; vecs[2].max_gap = 0; vecs[2].sof_abort = 0;
    vecs[2].exp_res = 24; vecs[2].exp_fd = 1; vecs[2].hold0 = 8'd0;  vecs[2].hold2 = 8'd0;
    vecs[2].col0 = '{0, 0, 0, 255, 255, 0, 0, 0};
    vecs[2].col2 = '{0, 0, 0, 255, 255, 0, 0, 0};

    vecs[3].name = "ramp_gaps"; vecs[3].pat = 1; vecs[3].max_gap = 3; vecs[3].sof_abort = 0;
    vecs[3].exp_res = 24; vecs[3].exp_fd = 1; vecs[3].hold0 = 8'd80; vecs[3].hold2 = 8'd20;
    vecs[3].col0 = '{default: 8'd80}; vecs[3].col2 = '{default: 8'd20};

    // Aborted frame emits row 2 (6) + (3,2) only; (3,3),(3,4) are in flight at sof. Then 24 from the full frame.
    vecs[4].name = "sof_abort"; vecs[4].pat = 3; vecs[4].max_gap = 0; vecs[4].sof_abort = 1;
    vecs[4].exp_res = 31; vecs[4].exp_fd = 1; vecs[4].hold0 = 8'd0;  vecs[4].hold2 = 8'd0;
    vecs[4].col0 = '{default: 8'd0};  vecs[4].col2 = '{default: 8'd0};

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset res_valid0", rv0, 0);
    check("reset res_data0", rd0, 0);
    check("reset res_hold0", rh0, 0);
    check("reset frame_done0", fd0, 0);
    check("reset res_valid2", rv2, 0);
    check("reset res_hold2", rh2, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      res_cnt0 = 0; res_cnt2 = 0; fd_cnt0 = 0; fd_cnt2 = 0;
      if (vecs[i].sof_abort) run_frame(i, 3, 5, 1'b1);
      run_frame(i, -1, -1, 1'b1);
      end_checks(vecs[i].name, vecs[i].exp_res, vecs[i].exp_fd, vecs[i].hold0, vecs[i].hold2);
    end

    // Reset mid-frame while a ramp result is on the outputs and another is in flight.
    res_cnt0 = 0; res_cnt2 = 0; fd_cnt0 = 0; fd_cnt2 = 0;
    run_frame(1, 3, 5, 1'b1);
    @(posedge clk);
    #1;
    check("pre_reset res_valid0", rv0, 1);
    check("pre_reset res_hold0", rh0, 80);
    check("pre_reset res_hold2", rh2, 20);
    q.delete();
    #1 reset_n = 1'b0;
    #1;
    check("async_reset res_valid0", rv0, 0);
    check("async_reset res_data0", rd0, 0);
    check("async_reset res_hold0", rh0, 0);
    check("async_reset frame_done0", fd0, 0);
    check("async_reset res_data2", rd2, 0);
    check("async_reset res_hold2", rh2, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    res_cnt0 = 0; res_cnt2 = 0; fd_cnt0 = 0; fd_cnt2 = 0;
    run_frame(1, -1, -1, 1'b0);
    end_checks("post_reset", 24, 1, 8'd80, 8'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
